// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// start/valid handshake, FSM and accumulator datapath in one block.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;

    // {carry,acc} after the conditional add; the carry is shifted straight
    // into acc's MSB, so it never needs its own register.
    always_comb begin
        sum = {1'b0, acc};
        if (mq[0])
            sum = {1'b0, acc} + {1'b0, mcand};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        mcand <= a;
                        acc   <= '0;
                        mq    <= b;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= sum[WIDTH:1];
                    mq    <= {sum[0], mq[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state   <= DONE;
                        product <= {sum, mq[WIDTH-1:1]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register only; no path from start.
    assign busy  = (state == RUN);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench: WIDTH=8 and WIDTH=16 instances checked every cycle against a
// latency/arithmetic model, plus directed literal cases on the 8-bit unit.
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        reset;
    logic        s8, busy8, valid8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        s16, busy16, valid16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    int total = 0;
    int bad = 0;
    bit go = 0;
    bit done16 = 0;

    // Model: an accepted op occupies WIDTH cycles, then one valid cycle.
    int          rem[2];
    logic [31:0] pend[2];
    logic [31:0] eprod[2];
    bit          evld[2];

    shift_add_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .valid(valid8), .product(product8)
    );
    shift_add_multiplier #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(s16), .a(a16), .b(b16),
        .busy(busy16), .valid(valid16), .product(product16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mstep(input int i, input int w, input bit st, input logic [31:0] prod);
        if (rem[i] > 0) begin
            rem[i]--;
            evld[i] = (rem[i] == 0);
            if (rem[i] == 0) eprod[i] = pend[i];
        end else begin
            evld[i] = 0;
            if (st) begin
                rem[i]  = w;
                pend[i] = prod;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                rem[i] = 0; evld[i] = 0; eprod[i] = '0; pend[i] = '0;
            end
        end else begin
            mstep(0, 8,  s8,  32'(a8)  * 32'(b8));
            mstep(1, 16, s16, 32'(a16) * 32'(b16));
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("busy8",     32'(busy8),   32'(rem[0] > 0));
            chk("valid8",    32'(valid8),  32'(evld[0]));
            chk("product8",  32'(product8), eprod[0]);
            chk("busy16",    32'(busy16),  32'(rem[1] > 0));
            chk("valid16",   32'(valid16), 32'(evld[1]));
            chk("product16", product16,     eprod[1]);
        end
    end

    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] lit, input bit glitch);
        int cnt;
        @(negedge clk); s8 = 1; a8 = x; b8 = y;
        @(negedge clk); s8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); cnt = 1;
        while (!valid8 && cnt < 30) begin
            @(negedge clk); cnt++;
            if (glitch && cnt == 3) begin s8 = 1; a8 = 8'd3; b8 = 8'd3; end
            else s8 = 0;
        end
        chk("latency8", 32'(cnt), 32'd9);
        chk("lit_product8", 32'(product8), 32'(lit));
        chk("model_pin", eprod[0], 32'(lit));
        @(negedge clk);
        chk("valid_pulse8", 32'(valid8), 32'd0);
        chk("hold8", 32'(product8), 32'(lit));
    endtask

    // 16-bit unit: random start/operands every cycle, including starts during RUN.
    initial begin
        s16 = 0; a16 = '0; b16 = '0;
        wait (go);
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            s16 = 1'($urandom_range(0, 1));
            a16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        end
        s16 = 0;
        done16 = 1;
    end

    initial begin
        int cnt;
        reset = 0; s8 = 0; a8 = '0; b8 = '0;
        @(posedge clk); #1;
        go = 1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_valid", 32'(valid8), 32'd0);
        chk("rst_product", 32'(product8), 32'd0);
        @(negedge clk); reset = 1;

        op8(8'd13,  8'd11,  16'd143,   0);
        op8(8'd255, 8'd255, 16'hFE01,  0);
        op8(8'd0,   8'd200, 16'd0,     0);
        op8(8'd200, 8'd0,   16'd0,     0);
        op8(8'd7,   8'd6,   16'd42,    1);

        // Held start: back-to-back results every WIDTH+1 cycles.
        @(negedge clk); s8 = 1; a8 = 8'd5; b8 = 8'd9;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!valid8 && cnt < 30);
            chk("b2b_latency", 32'(cnt), 32'd9);
            chk("b2b_product", 32'(product8), 32'd45);
        end
        s8 = 0;
        @(negedge clk);
        chk("b2b_stop", 32'(valid8), 32'd0);

        // Async reset in the middle of RUN.
        @(negedge clk); s8 = 1; a8 = 8'd100; b8 = 8'd100;
        @(negedge clk); s8 = 0;
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_valid", 32'(valid8), 32'd0);
        chk("abort_product", 32'(product8), 32'd0);
        chk("abort_product16", product16, 32'd0);
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(valid8), 32'd0);
        end
        reset = 1;
        op8(8'd2, 8'd3, 16'd6, 0);

        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            s8 = 1'($urandom_range(0, 1));
            a8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            b8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        end
        s8 = 0;

        cnt = 0;
        while (!done16 && cnt < 20000) begin @(negedge clk); cnt++; end
        if (!done16) chk("timeout16", 32'd0, 32'd1);
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
